// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
//   Shared constants for the SAP-1 control sequencer:
//     - opcode values (IR[7:4])
//     - one-hot T-state encodings (bit0 = T1)
//     - control-word bit indices and a helper that builds a one-bit word
// -----------------------------------------------------------------------------
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JC  = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_MAR_LD  = 2;
  localparam int CW_RAM_OUT = 3;
  localparam int CW_IR_LD   = 4;
  localparam int CW_IR_OUT  = 5;
  localparam int CW_A_LD    = 6;
  localparam int CW_A_OUT   = 7;
  localparam int CW_B_LD    = 8;
  localparam int CW_SUB     = 9;
  localparam int CW_SUM_WR  = 10;
  localparam int CW_OUT_LD  = 11;
  localparam int CW_PC_LD   = 12;
  localparam int CW_W       = 13;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // One-hot control word with only bit idx set.
  function automatic ctrl_word_t cw(input int idx);
    return ctrl_word_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// -----------------------------------------------------------------------------
// sap1_ring_counter
//   One-hot ring counter, T1 -> T2 -> ... -> T(NUM_T) -> T1.
//   Ports:
//     clk       in   system clock
//     rst_n     in   async active-low reset, ring returns to bit0 (T1)
//     i_adv     in   rotate by one position on this clock
//     i_freeze  in   hold the ring regardless of i_adv
//     o_ring    out  one-hot current position
// -----------------------------------------------------------------------------
module sap1_ring_counter #(
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  logic             i_freeze,
  output logic [NUM_T-1:0] o_ring
);

  logic [NUM_T-1:0] r_ring;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring <= {{(NUM_T-1){1'b0}}, 1'b1};
    end else if (i_adv && !i_freeze) begin
      r_ring <= {r_ring[NUM_T-2:0], r_ring[NUM_T-1]};
    end
  end

  assign o_ring = r_ring;

endmodule

// File: rtl/sap1_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_control_sequencer
//   Control sequencer for the SAP-1 datapath. A 6-step one-hot ring (T1..T6)
//   plus the IR opcode is decoded combinationally into the control word, so
//   every control is valid for the whole T-state. ALU flags are latched at
//   the edge that ends an ADD/SUB T6. Free-run or single-step operation.
//
//   Optional feature macro: SAP1_COND_JUMP_EN
//     defined   : JMP/JC/JZ drive ir_out,pc_ld in T4 (JC/JZ conditional)
//     undefined : those opcodes are NOPs, pc_ld is never asserted
//
//   Ports:
//     clk, rst_n             clock, async active-low reset
//     opcode                 IR[7:4], stable from T4 onward
//     carry_flg, zero_flg    live ALU flags
//     step_mode, step        single-step mode and (synchronous) step request
//     t_state                one-hot T-state, bit0 = T1
//     pc_inc .. pc_ld        control word outputs (all 0 while rst_n = 0)
//     hlt                    halted indicator
//     carry_q, zero_q        latched flags
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   T1         | fetch: PC -> MAR
//   T2         | fetch: PC increment
//   T3         | fetch: RAM -> IR
//   T4         | execute step 1 (address / output / jump / halt decision)
//   T5         | execute step 2 (memory operand)
//   T6         | execute step 3 (ALU writeback)
//   HALTED     | ring frozen at T5, hlt = 1, no controls; reset only exit
// -----------------------------------------------------------------------------
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             carry_flg,
  input  logic             zero_flg,
  input  logic             step_mode,
  input  logic             step,
  output logic [NUM_T-1:0] t_state,
  output logic             pc_inc,
  output logic             pc_out,
  output logic             mar_ld,
  output logic             ram_out,
  output logic             ir_ld,
  output logic             ir_out,
  output logic             a_ld,
  output logic             a_out,
  output logic             b_ld,
  output logic             sub,
  output logic             sum_wr,
  output logic             out_ld,
  output logic             pc_ld,
  output logic             hlt,
  output logic             carry_q,
  output logic             zero_q
);

  logic             r_step_d;
  logic             r_halted;
  logic             r_carry;
  logic             r_zero;

  logic [NUM_T-1:0] w_ring;
  logic             w_step_rise;
  logic             w_adv;
  logic             w_is_alu;
  ctrl_word_t       w_cw_dec;
  ctrl_word_t       w_cw;

  // A held step request advances only once: only its rising edge counts.
  assign w_step_rise = step & ~r_step_d;
  assign w_adv       = step_mode ? w_step_rise : 1'b1;
  assign w_is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);

  sap1_ring_counter #(
    .NUM_T (NUM_T)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_adv    (w_adv),
    .i_freeze (r_halted),
    .o_ring   (w_ring)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  // Halt is taken on the edge that leaves T4, so the ring lands on T5 and
  // stays there (freeze is the registered halt flag, still 0 on that edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (w_adv && !r_halted && (w_ring == T4) && (opcode == OP_HLT)) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_adv && !r_halted && (w_ring == T6) && w_is_alu) begin
      r_carry <= carry_flg;
      r_zero  <= zero_flg;
    end
  end

  always_comb begin
    w_cw_dec = '0;
    case (w_ring)
      T1: w_cw_dec = cw(CW_PC_OUT) | cw(CW_MAR_LD);
      T2: w_cw_dec = cw(CW_PC_INC);
      T3: w_cw_dec = cw(CW_RAM_OUT) | cw(CW_IR_LD);
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: w_cw_dec = cw(CW_IR_OUT) | cw(CW_MAR_LD);
          OP_OUT:                 w_cw_dec = cw(CW_A_OUT) | cw(CW_OUT_LD);
`ifdef SAP1_COND_JUMP_EN
          OP_JMP:                 w_cw_dec = cw(CW_IR_OUT) | cw(CW_PC_LD);
          OP_JC: begin
            if (r_carry) w_cw_dec = cw(CW_IR_OUT) | cw(CW_PC_LD);
          end
          OP_JZ: begin
            if (r_zero) w_cw_dec = cw(CW_IR_OUT) | cw(CW_PC_LD);
          end
`endif
          default: w_cw_dec = '0;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:  w_cw_dec = cw(CW_RAM_OUT) | cw(CW_A_LD);
          OP_ADD:  w_cw_dec = cw(CW_RAM_OUT) | cw(CW_B_LD);
          OP_SUB:  w_cw_dec = cw(CW_RAM_OUT) | cw(CW_B_LD) | cw(CW_SUB);
          default: w_cw_dec = '0;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD:  w_cw_dec = cw(CW_SUM_WR) | cw(CW_A_LD);
          OP_SUB:  w_cw_dec = cw(CW_SUM_WR) | cw(CW_A_LD) | cw(CW_SUB);
          default: w_cw_dec = '0;
        endcase
      end
      default: w_cw_dec = '0;
    endcase
  end

  // rst_n gates the word directly: the ring snaps to T1 asynchronously, and
  // without this gate T1's pc_out/mar_ld would pulse during reset.
  assign w_cw = (rst_n && !r_halted) ? w_cw_dec : '0;

  assign t_state = w_ring;
  assign pc_inc  = w_cw[CW_PC_INC];
  assign pc_out  = w_cw[CW_PC_OUT];
  assign mar_ld  = w_cw[CW_MAR_LD];
  assign ram_out = w_cw[CW_RAM_OUT];
  assign ir_ld   = w_cw[CW_IR_LD];
  assign ir_out  = w_cw[CW_IR_OUT];
  assign a_ld    = w_cw[CW_A_LD];
  assign a_out   = w_cw[CW_A_OUT];
  assign b_ld    = w_cw[CW_B_LD];
  assign sub     = w_cw[CW_SUB];
  assign sum_wr  = w_cw[CW_SUM_WR];
  assign out_ld  = w_cw[CW_OUT_LD];
  // Without the jump feature nothing in the decode sets this bit, so it
  // reduces to a constant 0.
  assign pc_ld   = w_cw[CW_PC_LD];
  assign hlt     = r_halted;
  assign carry_q = r_carry;
  assign zero_q  = r_zero;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
module tb_sap1_control_sequencer;

  localparam logic [12:0] M_PCI  = 13'h1000;
  localparam logic [12:0] M_PCO  = 13'h0800;
  localparam logic [12:0] M_MAR  = 13'h0400;
  localparam logic [12:0] M_RAMO = 13'h0200;
  localparam logic [12:0] M_IRL  = 13'h0100;
  localparam logic [12:0] M_IRO  = 13'h0080;
  localparam logic [12:0] M_AL   = 13'h0040;
  localparam logic [12:0] M_AO   = 13'h0020;
  localparam logic [12:0] M_BL   = 13'h0010;
  localparam logic [12:0] M_SUB  = 13'h0008;
  localparam logic [12:0] M_SUM  = 13'h0004;
  localparam logic [12:0] M_OUT  = 13'h0002;
  localparam logic [12:0] M_PCL  = 13'h0001;
`ifdef SAP1_COND_JUMP_EN
  localparam logic [12:0] J_TAKEN = M_IRO | M_PCL;
`else
  localparam logic [12:0] J_TAKEN = 13'h0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       carry_flg = 1'b0, zero_flg = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [5:0] t_state;
  logic pc_inc, pc_out, mar_ld, ram_out, ir_ld, ir_out, a_ld, a_out, b_ld;
  logic sub, sum_wr, out_ld, pc_ld, hlt, carry_q, zero_q;
  logic [12:0] obs_ctrl;

  assign obs_ctrl = {pc_inc, pc_out, mar_ld, ram_out, ir_ld, ir_out, a_ld, a_out,
                     b_ld, sub, sum_wr, out_ld, pc_ld};

  always #5 clk = ~clk;

  sap1_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .carry_flg(carry_flg),
    .zero_flg(zero_flg), .step_mode(step_mode), .step(step), .t_state(t_state),
    .pc_inc(pc_inc), .pc_out(pc_out), .mar_ld(mar_ld), .ram_out(ram_out),
    .ir_ld(ir_ld), .ir_out(ir_out), .a_ld(a_ld), .a_out(a_out), .b_ld(b_ld),
    .sub(sub), .sum_wr(sum_wr), .out_ld(out_ld), .pc_ld(pc_ld), .hlt(hlt),
    .carry_q(carry_q), .zero_q(zero_q)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: instruction step counter k (0..5 = T1..T6), halt, flags
  // and a micro-program table indexed by opcode and execute step.
  int          m_k;
  bit          m_halt, m_c, m_z, m_prev;
  logic [12:0] mprog [16][3];

  task automatic model_reset();
    m_k = 0; m_halt = 0; m_c = 0; m_z = 0; m_prev = 0;
  endtask

  function automatic logic [12:0] model_ctrl();
    logic [12:0] v;
    if (m_halt) return 13'h0;
    case (m_k)
      0:       v = M_PCO | M_MAR;
      1:       v = M_PCI;
      2:       v = M_RAMO | M_IRL;
      default: begin
        v = mprog[opcode][m_k-3];
        if (opcode == 4'h4 && !m_c) v = 13'h0;
        if (opcode == 4'h5 && !m_z) v = 13'h0;
      end
    endcase
    return v;
  endfunction

  function automatic logic [5:0] model_t();
    logic [5:0] t;
    if (m_halt) return 6'b010000;
    t = 6'b000001;
    t = t << m_k;
    return t;
  endfunction

  function automatic logic [31:0] pk(input logic [5:0] t, input logic [12:0] c,
                                     input logic h, input logic cq, input logic zq);
    return {10'd0, t, c, h, cq, zq};
  endfunction

  task automatic model_edge();
    bit adv;
    adv = !m_halt && (!step_mode || (step && !m_prev));
    if (adv) begin
      if (m_k == 5 && (opcode == 4'h1 || opcode == 4'h2)) begin
        m_c = carry_flg; m_z = zero_flg;
      end
      if (m_k == 3 && opcode == 4'hF) m_halt = 1;
      m_k = (m_k + 1) % 6;
    end
    m_prev = step;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string name);
    chk(name, pk(t_state, obs_ctrl, hlt, carry_q, zero_q),
              pk(model_t(), model_ctrl(), m_halt, m_c, m_z));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        cf, zf;
    logic [12:0] c4, c5, c6;
    logic        eq_c, eq_z;
  } vec_t;

  vec_t vecs [9];

  initial begin
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) mprog[o][s] = 13'h0;
    mprog[0][0] = M_IRO | M_MAR;  mprog[0][1] = M_RAMO | M_AL;
    mprog[1][0] = M_IRO | M_MAR;  mprog[1][1] = M_RAMO | M_BL;
    mprog[1][2] = M_SUM | M_AL;
    mprog[2][0] = M_IRO | M_MAR;  mprog[2][1] = M_RAMO | M_BL | M_SUB;
    mprog[2][2] = M_SUM | M_AL | M_SUB;
    mprog[14][0] = M_AO | M_OUT;
    mprog[3][0] = J_TAKEN; mprog[4][0] = J_TAKEN; mprog[5][0] = J_TAKEN;

    //          op     cf    zf    T4             T5                    T6                    c     z
    vecs[0] = '{4'h0, 1'b1, 1'b1, M_IRO | M_MAR, M_RAMO | M_AL,         13'h0,                1'b0, 1'b0};
    vecs[1] = '{4'h1, 1'b1, 1'b0, M_IRO | M_MAR, M_RAMO | M_BL,         M_SUM | M_AL,         1'b1, 1'b0};
    vecs[2] = '{4'h2, 1'b0, 1'b1, M_IRO | M_MAR, M_RAMO | M_BL | M_SUB, M_SUM | M_AL | M_SUB, 1'b0, 1'b1};
    vecs[3] = '{4'hE, 1'b1, 1'b0, M_AO | M_OUT,  13'h0,                 13'h0,                1'b0, 1'b1};
    vecs[4] = '{4'h7, 1'b1, 1'b1, 13'h0,         13'h0,                 13'h0,                1'b0, 1'b1};
    vecs[5] = '{4'h3, 1'b1, 1'b0, J_TAKEN,       13'h0,                 13'h0,                1'b0, 1'b1};
    vecs[6] = '{4'h4, 1'b1, 1'b0, 13'h0,         13'h0,                 13'h0,                1'b0, 1'b1};
    vecs[7] = '{4'h5, 1'b0, 1'b0, J_TAKEN,       13'h0,                 13'h0,                1'b0, 1'b1};
    vecs[8] = '{4'h1, 1'b0, 1'b0, M_IRO | M_MAR, M_RAMO | M_BL,         M_SUM | M_AL,         1'b0, 1'b0};

    // Reset held for 3 clocks
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'(obs_ctrl), 32'(13'h0));
    chk("rst_tstate", 32'(t_state), 32'(6'b000001));
    rst_n = 1'b1;
    #1;
    chk("post_rst_ctrl", 32'(obs_ctrl), 32'(M_PCO | M_MAR));
    check_model("post_rst_all");

    // Table-driven single instructions, free-run
    for (int i = 0; i < 9; i++) begin
      logic [12:0] exp;
      logic [5:0]  et;
      opcode = vecs[i].op; carry_flg = vecs[i].cf; zero_flg = vecs[i].zf;
      for (int s = 0; s < 6; s++) begin
        case (s)
          0: exp = M_PCO | M_MAR;
          1: exp = M_PCI;
          2: exp = M_RAMO | M_IRL;
          3: exp = vecs[i].c4;
          4: exp = vecs[i].c5;
          default: exp = vecs[i].c6;
        endcase
        et = 6'b000001;
        et = et << s;
        chk($sformatf("vec%0d_T%0d", i, s + 1), 32'({t_state, obs_ctrl, hlt}), 32'({et, exp, 1'b0}));
        cycle();
      end
      chk($sformatf("vec%0d_flags", i), 32'({t_state, carry_q, zero_q}),
          32'({6'b000001, vecs[i].eq_c, vecs[i].eq_z}));
    end

    // Single-step: held step -> one advance, three pulses -> three advances
    opcode = 4'h7; step_mode = 1'b1; step = 1'b1;
    repeat (5) cycle();
    chk("step_held", 32'(t_state), 32'(6'b000010));
    step = 1'b0; cycle();
    chk("step_idle", 32'(t_state), 32'(6'b000010));
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle();
    end
    chk("step_pulses", 32'(t_state), 32'(6'b010000));
    check_model("step_model");
    step_mode = 1'b0;
    repeat (2) cycle();
    chk("step_back_t1", 32'(t_state), 32'(6'b000001));

    // ADD latching both flags, then reset in the middle of the next ADD's T5
    opcode = 4'h1; carry_flg = 1'b1; zero_flg = 1'b1;
    repeat (6) cycle();
    chk("add_flags_set", 32'({carry_q, zero_q}), 32'(2'b11));
    repeat (4) cycle();
    chk("add_t5_bld", 32'({t_state, b_ld, ram_out}), 32'({6'b010000, 1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(obs_ctrl), 32'(13'h0));
    chk("async_rst_state", 32'({t_state, carry_q, zero_q, hlt}), 32'({6'b000001, 3'b000}));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model("rst_release");

    // HLT: freeze at T5 with hlt=1 for 20 clocks
    opcode = 4'hF; carry_flg = 1'b0; zero_flg = 1'b0;
    repeat (3) cycle();
    chk("hlt_t4", 32'({t_state, obs_ctrl, hlt}), 32'({6'b001000, 13'h0, 1'b0}));
    cycle();
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("halted_%0d", c), 32'({t_state, obs_ctrl, hlt}), 32'({6'b010000, 13'h0, 1'b1}));
      cycle();
    end

    // Randomised run against the reference model
    rst_n = 1'b0; step = 1'b0; step_mode = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int halt_cnt = 0;
      for (int n = 0; n < 1200; n++) begin
        if (m_halt) halt_cnt++;
        if (halt_cnt > 8) begin
          halt_cnt = 0;
          rst_n = 1'b0; step = 1'b0;
          model_reset();
          @(negedge clk);
          rst_n = 1'b1;
          #1;
          check_model("rand_rst");
        end
        if (m_k == 0 && !m_halt)
          opcode = ($urandom_range(0, 31) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        carry_flg = 1'($urandom_range(0, 1));
        zero_flg  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
        step = ($urandom_range(0, 2) == 0);
        cycle();
        check_model($sformatf("rand_%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
